// File: rtl/ranger_pkg.sv
// Shared types and constants for the multi-channel ultrasonic ranger.
package ranger_pkg;

  typedef enum logic [2:0] {IDLE, TRIG, WAIT, MEAS, DONE} state_t;

  localparam logic [15:0] OOR_BCD = 16'h9999;
  localparam logic [15:0] OOR_BIN = 16'hFFFF;

endpackage

// File: rtl/bcd_cnt4.sv
// Four-digit BCD counter: synchronous clear, increment, saturates at 9999.
module bcd_cnt4 (
  input  logic        CLK_50M,
  input  logic        RST,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] bcd
);

  logic [15:0] bcd_d;
  logic        carry;

  // Ripple the carry through all digits in one cycle so no A-F digit is ever stored.
  always_comb begin
    bcd_d = bcd;
    carry = inc && (bcd != 16'h9999);
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (bcd[4*i +: 4] == 4'd9) begin
          bcd_d[4*i +: 4] = 4'd0;
        end else begin
          bcd_d[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
          carry           = 1'b0;
        end
      end
    end
    if (clr) bcd_d = '0;
  end

  always_ff @(posedge CLK_50M or negedge RST) begin
    if (!RST) bcd <= '0;
    else      bcd <= bcd_d;
  end

endmodule

// File: rtl/ultrasonic_ranger_mc.sv
// Round-robin HC-SR04 style ranger: triggers one sensor per slot, times its echo into
// distance units and keeps a result register plus out-of-range flag per channel.
module ultrasonic_ranger_mc
  import ranger_pkg::*;
#(
  parameter int unsigned  NUM_CH      = 2,
  parameter int unsigned  PERIOD_CYC  = 1_000_000,
  parameter int unsigned  TRIG_CYC    = 500,
  parameter int unsigned  UNIT_CYC    = 2915,
  parameter int unsigned  RISE_TO_CYC = 50_000,
  parameter int unsigned  MAX_UNITS   = 400,
  parameter int unsigned  BCD_MODE    = 1,
  localparam int unsigned CHW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  CLK_50M,
  input  logic                  RST,
  input  logic                  en,
  input  logic [NUM_CH-1:0]     Echo,
  output logic [NUM_CH-1:0]     Trig,
  output logic [16*NUM_CH-1:0]  dist_data,
  output logic [NUM_CH-1:0]     dist_oor,
  output logic                  dist_valid,
  output logic [CHW-1:0]        dist_ch
);

  localparam logic [CHW-1:0]    LastCh = CHW'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] OneCh  = NUM_CH'(1);
  localparam logic [15:0]       MaxU   = 16'(MAX_UNITS);

  state_t          state_q;
  logic [31:0]     period_q, cnt_q, presc_q;
  logic [15:0]     units_q, bcd_val, result;
  logic [CHW-1:0]  cur_ch_q;
  logic            oor_q;
  logic [NUM_CH-1:0] echo_s2, echo_s3;
  logic            slot_tick, unit_tick, rise, fall;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_sync
    logic [2:0] sh_q;
    always_ff @(posedge CLK_50M or negedge RST) begin
      if (!RST) sh_q <= '0;
      else      sh_q <= {sh_q[1:0], Echo[k]};
    end
    assign echo_s2[k] = sh_q[1];
    assign echo_s3[k] = sh_q[2];
  end

  assign rise      = echo_s2[cur_ch_q] & ~echo_s3[cur_ch_q];
  assign fall      = ~echo_s2[cur_ch_q] & echo_s3[cur_ch_q];
  assign slot_tick = (period_q == PERIOD_CYC - 1);
  assign unit_tick = (presc_q == UNIT_CYC - 1);
  assign result    = (BCD_MODE != 0) ? bcd_val : units_q;

  always_ff @(posedge CLK_50M or negedge RST) begin
    if (!RST) period_q <= '0;
    else      period_q <= slot_tick ? '0 : period_q + 32'd1;
  end

  always_ff @(posedge CLK_50M or negedge RST) begin
    if (!RST) begin
      presc_q <= '0;
      units_q <= '0;
    end else if (state_q == WAIT) begin
      presc_q <= '0;
      units_q <= '0;
    end else if (state_q == MEAS) begin
      presc_q <= unit_tick ? '0 : presc_q + 32'd1;
      if (unit_tick) units_q <= units_q + 16'd1;
    end
  end

  bcd_cnt4 u_bcd (
    .CLK_50M (CLK_50M),
    .RST     (RST),
    .clr     (state_q == WAIT),
    .inc     ((state_q == MEAS) && unit_tick),
    .bcd     (bcd_val)
  );

  always_ff @(posedge CLK_50M or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_ch_q   <= '0;
      oor_q      <= 1'b0;
      Trig       <= '0;
      dist_data  <= '0;
      dist_oor   <= '0;
      dist_valid <= 1'b0;
      dist_ch    <= '0;
    end else begin
      dist_valid <= 1'b0;
      // Losing enable abandons the measurement without touching results or the channel pointer.
      if (!en && (state_q == TRIG || state_q == WAIT || state_q == MEAS)) begin
        state_q <= IDLE;
        Trig    <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (en && slot_tick) begin
              state_q <= TRIG;
              cnt_q   <= '0;
              Trig    <= OneCh << cur_ch_q;
            end
          end
          TRIG: begin
            if (cnt_q == TRIG_CYC - 1) begin
              state_q <= WAIT;
              cnt_q   <= '0;
              Trig    <= '0;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
          WAIT: begin
            if (rise) begin
              state_q <= MEAS;
            end else if (cnt_q == RISE_TO_CYC - 1) begin
              state_q <= DONE;
              oor_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
          MEAS: begin
            // A fall on the same cycle as the overflow still counts as a valid reading.
            if (fall) begin
              state_q <= DONE;
              oor_q   <= 1'b0;
            end else if (unit_tick && units_q == MaxU) begin
              state_q <= DONE;
              oor_q   <= 1'b1;
            end
          end
          DONE: begin
            dist_data[cur_ch_q*16 +: 16] <= oor_q ? ((BCD_MODE != 0) ? OOR_BCD : OOR_BIN) : result;
            dist_oor[cur_ch_q]           <= oor_q;
            dist_valid                   <= 1'b1;
            dist_ch                      <= cur_ch_q;
            cur_ch_q                     <= (cur_ch_q == LastCh) ? '0 : cur_ch_q + 1'b1;
            state_q                      <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ultrasonic_ranger_mc.sv
// Bench for ultrasonic_ranger_mc: BCD and binary instances on shared stimulus, checked each
// cycle against a slot-level timing/arithmetic model plus a few literal expectations.
module tb_ultrasonic_ranger_mc;

  localparam int UNIT = 10, PERIOD = 2000, TRIGC = 5, RISE_TO = 200, MAXU = 50;

  logic        CLK_50M = 1'b0;
  logic        RST = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  Echo = 2'b00;
  logic [1:0]  trig_b, oor_b, trig_n, oor_n;
  logic [31:0] data_b, data_n;
  logic        valid_b, valid_n;
  logic [0:0]  ch_b, ch_n;

  int n_vec = 0, n_fail = 0;
  int cyc = 0;
  int next_slot;
  // Model: expected trigger window and the next expected result event.
  int m_ts = -100, m_tlen = TRIGC, m_tch = 0;
  int m_vcyc = -1, m_vch = 0, m_vunits = 0;
  bit m_voor = 1'b0;
  int mu [2];
  bit mo [2];
  int first_trig = -1;

  ultrasonic_ranger_mc #(
    .NUM_CH(2), .PERIOD_CYC(PERIOD), .TRIG_CYC(TRIGC), .UNIT_CYC(UNIT),
    .RISE_TO_CYC(RISE_TO), .MAX_UNITS(MAXU), .BCD_MODE(1)
  ) dut (
    .CLK_50M(CLK_50M), .RST(RST), .en(en), .Echo(Echo), .Trig(trig_b),
    .dist_data(data_b), .dist_oor(oor_b), .dist_valid(valid_b), .dist_ch(ch_b)
  );

  ultrasonic_ranger_mc #(
    .NUM_CH(2), .PERIOD_CYC(PERIOD), .TRIG_CYC(TRIGC), .UNIT_CYC(UNIT),
    .RISE_TO_CYC(RISE_TO), .MAX_UNITS(MAXU), .BCD_MODE(0)
  ) dut_bin (
    .CLK_50M(CLK_50M), .RST(RST), .en(en), .Echo(Echo), .Trig(trig_n),
    .dist_data(data_n), .dist_oor(oor_n), .dist_valid(valid_n), .dist_ch(ch_n)
  );

  always #10 CLK_50M = ~CLK_50M;

  always @(posedge CLK_50M or negedge RST) begin
    if (!RST) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] exp_bcd(input int u, input bit o);
    if (o) return 16'h9999;
    return {4'((u / 1000) % 10), 4'((u / 100) % 10), 4'((u / 10) % 10), 4'(u % 10)};
  endfunction

  function automatic logic [15:0] exp_bin(input int u, input bit o);
    return o ? 16'hFFFF : 16'(u);
  endfunction

  always @(negedge CLK_50M) begin : compare
    int u0, u1;
    bit o0, o1, ev;
    logic [1:0] et;
    if (!RST) begin
      chk("reset_outputs_bcd", {trig_b, valid_b, oor_b, data_b, ch_b}, '0);
      chk("reset_outputs_bin", {trig_n, valid_n, oor_n, data_n, ch_n}, '0);
      mu[0] <= 0; mu[1] <= 0; mo[0] <= 1'b0; mo[1] <= 1'b0;
      first_trig <= -1;
    end else begin
      u0 = mu[0]; u1 = mu[1]; o0 = mo[0]; o1 = mo[1];
      ev = (cyc == m_vcyc);
      if (ev) begin
        if (m_vch == 0) begin u0 = m_vunits; o0 = m_voor; end
        else            begin u1 = m_vunits; o1 = m_voor; end
        mu[m_vch] <= m_vunits;
        mo[m_vch] <= m_voor;
      end
      et = (cyc >= m_ts && cyc < m_ts + m_tlen) ? (2'b01 << m_tch) : 2'b00;
      chk("outputs_bcd", {trig_b, valid_b, oor_b, data_b},
          {et, ev, o1, o0, exp_bcd(u1, o1), exp_bcd(u0, o0)});
      chk("outputs_bin", {trig_n, valid_n, oor_n, data_n},
          {et, ev, o1, o0, exp_bin(u1, o1), exp_bin(u0, o0)});
      if (ev) chk("dist_ch", {ch_b, ch_n}, {2{1'(m_vch)}});
      if (first_trig < 0 && trig_b != 2'b00) first_trig <= cyc;
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge CLK_50M);
      #1;
    end
  endtask

  // mode 0 echo, 1 silent, 2 echo already high, 3 en drop in MEAS, 4 en drop in TRIG,
  // 5 reset in MEAS. d = cycles from Trig fall to Echo rise, n = echo high length.
  task automatic run_slot(input int ch, input int mode, input int d, input int n);
    int s, f;
    s = next_slot;
    f = s + TRIGC;
    m_ts = s; m_tch = ch; m_tlen = (mode == 4) ? 3 : TRIGC;
    m_vch = ch; m_vunits = 0; m_voor = 1'b0;
    if (mode >= 3)                         m_vcyc = -1;
    else if (mode == 1 || d + 3 > RISE_TO) begin m_vcyc = f + RISE_TO + 1; m_voor = 1'b1; end
    else if (n > (MAXU + 1) * UNIT) begin m_vcyc = f + d + 3 + (MAXU + 1) * UNIT + 1; m_voor = 1'b1; end
    else begin m_vcyc = f + d + n + 4; m_vunits = n / UNIT; end
    if (mode == 2) begin
      Echo[ch] = 1'b1;
      wait_until(f + 2);
      Echo[ch] = 1'b0;
    end
    if (mode == 4) begin
      wait_until(s + 2);
      en = 1'b0;
      wait_until(s + 20);
      en = 1'b1;
    end else if (mode != 1) begin
      wait_until(f + d);
      Echo[ch] = 1'b1;
      if (mode == 5) begin
        wait_until(f + d + 33);
        RST = 1'b0;
        Echo[ch] = 1'b0;
        m_ts = -100;
        #1;
        chk("reset_mid_meas", {trig_b, valid_b, data_b}, '0);
        repeat (5) @(posedge CLK_50M);
        #1;
        RST = 1'b1;
        next_slot = PERIOD;
        return;
      end
      if (mode == 3) begin
        wait_until(f + d + 30);
        en = 1'b0;
      end
      wait_until(f + d + n);
      Echo[ch] = 1'b0;
    end
    if (mode == 3) begin
      wait_until(s + PERIOD + 10);
      en = 1'b1;
      next_slot = s + 2 * PERIOD;
    end else begin
      next_slot = s + PERIOD;
    end
    wait_until(next_slot - 10);
  endtask

  initial begin : watchdog
    #(20 * 60000);
    $display("FAIL watchdog: simulation exceeded 60000 cycles");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (4) @(posedge CLK_50M);
    #1;
    RST = 1'b1;
    en = 1'b1;
    next_slot = PERIOD;

    run_slot(0, 0, 10, 235);
    chk("ch0_235_bcd", data_b[15:0], 16'h0023);
    chk("ch0_235_bin", data_n[15:0], 16'h0017);
    chk("ch0_235_oor", oor_b[0], 1'b0);
    run_slot(1, 1, 0, 0);
    chk("ch1_timeout", {oor_b[1], data_b[31:16]}, {1'b1, 16'h9999});
    run_slot(0, 0, 10, 600);
    chk("ch0_600_bin", {oor_n[0], data_n[15:0]}, {1'b1, 16'hFFFF});
    run_slot(1, 0, 10, 510);
    chk("ch1_510_fall_wins", {oor_b[1], data_b[31:16]}, {1'b0, 16'h0051});
    run_slot(0, 0, 10, 511);
    run_slot(1, 2, 20, 100);
    chk("ch1_prehigh", data_b[31:16], 16'h0010);
    run_slot(0, 3, 10, 100);
    run_slot(0, 4, 0, 0);
    run_slot(0, 0, 10, 90);
    chk("ch0_90_bin", data_n[15:0], 16'd9);
    run_slot(1, 0, 197, 20);
    run_slot(0, 0, 198, 20);
    run_slot(1, 0, 10, 9);
    run_slot(0, 5, 10, 235);
    run_slot(0, 0, 10, 15);
    chk("first_trig_after_reset", first_trig, 2000);
    chk("ch0_after_reset", data_b, 32'h0000_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
